// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar control unit: state encodings and timing defaults.
package sonar_pkg;

  localparam int unsigned TEMPO_ESPERA_DEF   = 100_000_000;
  localparam int unsigned TIMEOUT_MEDIDA_DEF = 1_500_000;
  localparam int unsigned ESTADO_W           = 4;

  typedef enum logic [ESTADO_W-1:0] {
    E_INICIAL             = 4'd0,
    E_PREPARACAO          = 4'd1,
    E_ESPERA              = 4'd2,
    E_ACIONA_MEDIDA       = 4'd3,
    E_AGUARDA_MEDIDA      = 4'd4,
    E_ACIONA_TRANSMISSAO  = 4'd5,
    E_AGUARDA_TRANSMISSAO = 4'd6,
    E_GIRA                = 4'd7
  } estado_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Timer width large enough to hold the longest programmed interval minus one
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = max_u(a, b);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with async and sync clears; used as the shared FSM timer.
module contador_m #(
  parameter int unsigned M = 16,
  parameter int unsigned N = 4
) (
  input  logic         clock,
  input  logic         zera_as,
  input  logic         zera_s,
  input  logic         conta,
  output logic [N-1:0] q
);

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      q <= '0;
    end else if (zera_s) begin
      q <= '0;
    end else if (conta) begin
      if (q == N'(M - 1)) q <= '0;
      else                q <= q + N'(1);
    end
  end

endmodule

// File: rtl/sonar_uc.sv
// Sonar sweep control unit: settle, measure, transmit, step, with measurement timeout.
module sonar_uc
  import sonar_pkg::*;
#(
  parameter int unsigned TEMPO_ESPERA   = TEMPO_ESPERA_DEF,
  parameter int unsigned TIMEOUT_MEDIDA = TIMEOUT_MEDIDA_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       medida_pronto,
  input  logic       envio_pronto,
  output logic       zera,
  output logic       medir,
  output logic       transmitir,
  output logic       girar,
  output logic       ativo,
  output logic       erro_medida,
  output logic [3:0] db_estado
);

  localparam int unsigned TIMER_MAX = max_u(TEMPO_ESPERA, TIMEOUT_MEDIDA);
  localparam int unsigned TW        = timer_width(TEMPO_ESPERA, TIMEOUT_MEDIDA);

  estado_t       state, next_state;
  logic [TW-1:0] timer;
  logic          timer_clr_c, timer_cnt_c;
  logic          espera_fim_c, medida_fim_c;

  contador_m #(.M(TIMER_MAX), .N(TW)) u_timer (
    .clock   (clock),
    .zera_as (reset),
    .zera_s  (timer_clr_c),
    .conta   (timer_cnt_c),
    .q       (timer)
  );

  // Next-state and timer control
  always_comb begin
    next_state   = state;
    espera_fim_c = (timer == TW'(TEMPO_ESPERA - 1));
    medida_fim_c = (timer == TW'(TIMEOUT_MEDIDA - 1));
    case (state)
      E_INICIAL:             if (ligar) next_state = E_PREPARACAO;
      E_PREPARACAO:          next_state = E_ESPERA;
      E_ESPERA: begin
        if (!ligar)            next_state = E_INICIAL;
        else if (espera_fim_c) next_state = E_ACIONA_MEDIDA;
      end
      E_ACIONA_MEDIDA:       next_state = E_AGUARDA_MEDIDA;
      E_AGUARDA_MEDIDA: begin
        if (medida_pronto)     next_state = E_ACIONA_TRANSMISSAO;
        else if (medida_fim_c) next_state = E_GIRA;
      end
      E_ACIONA_TRANSMISSAO:  next_state = E_AGUARDA_TRANSMISSAO;
      E_AGUARDA_TRANSMISSAO: if (envio_pronto) next_state = E_GIRA;
      E_GIRA:                next_state = ligar ? E_ESPERA : E_INICIAL;
      default:               next_state = E_INICIAL;
    endcase
    timer_cnt_c = (state == E_ESPERA) || (state == E_AGUARDA_MEDIDA);
    // Clearing on exit keeps the counter from ever stepping past its terminal value
    timer_clr_c = !timer_cnt_c || (next_state != state);
  end

  // State register; outputs are loaded with the decode of the state being entered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= E_INICIAL;
      zera       <= 1'b0;
      medir      <= 1'b0;
      transmitir <= 1'b0;
      girar      <= 1'b0;
      ativo      <= 1'b0;
      db_estado  <= 4'd0;
    end else begin
      state      <= next_state;
      zera       <= (next_state == E_PREPARACAO);
      medir      <= (next_state == E_ACIONA_MEDIDA);
      transmitir <= (next_state == E_ACIONA_TRANSMISSAO);
      girar      <= (next_state == E_GIRA);
      ativo      <= (next_state != E_INICIAL);
      db_estado  <= next_state;
    end
  end

  // Sticky timeout flag, cleared only when a new sweep is prepared
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      erro_medida <= 1'b0;
    end else if (next_state == E_PREPARACAO) begin
      erro_medida <= 1'b0;
    end else if (state == E_AGUARDA_MEDIDA && !medida_pronto && medida_fim_c) begin
      erro_medida <= 1'b1;
    end
  end

endmodule
